// File: rtl/capturador_de_comandos.sv
// rtl/capturador_de_comandos.sv - switch/button capture: sync, debounce, registered command codes
//
// Samples eight slide switches and four active-low push buttons, passes each
// line through a two-flop synchroniser and an independent debounce counter,
// and presents registered user/function codes with per-channel change strobes.
//
// Ports:
//   Clk       in   1  system clock, rising edge
//   Reset_n   in   1  synchronous active-low reset
//   CH        in   8  raw switches, active-high, asynchronous
//   BTN       in   4  raw buttons, active-low, asynchronous
//   User0     out  3  {CH0,CH1,CH2} debounced
//   Func0     out  3  {CH3, BTN0 pressed, BTN1 pressed} debounced
//   User1     out  3  {CH4,CH5,CH6} debounced
//   Func1     out  3  {CH7, BTN2 pressed, BTN3 pressed} debounced
//   Changed0  out  1  one-cycle pulse when {User0,Func0} loads a new value
//   Changed1  out  1  one-cycle pulse when {User1,Func1} loads a new value
//
// Build option:
//   CAPT_STICKY_BTN_EN  when defined, each button output bit is a toggle latch
//                       that inverts on every accepted press and ignores releases.
//
// Parameters: DEB_CYCLES (2..65535) consecutive differing cycles before a new
// level is accepted; CNT_W counter width with 2**CNT_W > DEB_CYCLES.

module capturador_de_comandos #(
    parameter int unsigned DEB_CYCLES = 50000,
    parameter int unsigned CNT_W      = 16
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic [7:0] CH,
    input  logic [3:0] BTN,
    output logic [2:0] User0,
    output logic [2:0] Func0,
    output logic [2:0] User1,
    output logic [2:0] Func1,
    output logic       Changed0,
    output logic       Changed1
);

    localparam int unsigned N_LINES = 12;

    // Counter value on the cycle that accepts the new level.
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);

    // Line 0..7 = CH0..CH7, line 8..11 = BTN0..BTN3 (still active-low here).
    // Buttons reset to the released level so no press is seen out of reset.
    localparam logic [N_LINES-1:0] LINE_RST = {4'hF, 8'h00};

    logic [N_LINES-1:0] w_raw;
    logic [N_LINES-1:0] r_s1;
    logic [N_LINES-1:0] r_s2;
    logic [N_LINES-1:0] r_stable;
    logic [CNT_W-1:0]   r_cnt [N_LINES];
    logic [N_LINES-1:0] w_accept;

    logic [3:0]         w_btn_bit;
    logic [5:0]         w_code0;
    logic [5:0]         w_code1;
    logic [5:0]         r_out0;
    logic [5:0]         r_out1;
    logic               r_chg0;
    logic               r_chg1;

    assign w_raw = {BTN, CH};

    // A line accepts when it has differed from its stable value for the full
    // debounce window; the counter is then at its last value.
    always_comb begin
        w_accept = '0;
        for (int i = 0; i < N_LINES; i++) begin
            w_accept[i] = (r_s2[i] != r_stable[i]) && (r_cnt[i] == DEB_LAST);
        end
    end

    // Synchronisers and debounce counters. Any return to the stable level
    // before acceptance clears the counter, discarding the glitch.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            r_s1     <= LINE_RST;
            r_s2     <= LINE_RST;
            r_stable <= LINE_RST;
            for (int i = 0; i < N_LINES; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_s1 <= w_raw;
            r_s2 <= r_s1;
            for (int i = 0; i < N_LINES; i++) begin
                if (r_s2[i] == r_stable[i]) begin
                    r_cnt[i] <= '0;
                end else if (w_accept[i]) begin
                    r_stable[i] <= r_s2[i];
                    r_cnt[i]    <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end
            end
        end
    end

`ifdef CAPT_STICKY_BTN_EN
    logic [3:0] r_toggle;
    logic [3:0] w_press;

    // A press is an accepted transition from released (1) to pressed (0);
    // the toggle is updated on the same edge the stable value changes.
    assign w_press = w_accept[11:8] & r_stable[11:8];

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            r_toggle <= '0;
        end else begin
            r_toggle <= r_toggle ^ w_press;
        end
    end

    assign w_btn_bit = r_toggle;
`else
    assign w_btn_bit = ~r_stable[11:8];
`endif

    assign w_code0 = {r_stable[0], r_stable[1], r_stable[2],
                      r_stable[3], w_btn_bit[0], w_btn_bit[1]};
    assign w_code1 = {r_stable[4], r_stable[5], r_stable[6],
                      r_stable[7], w_btn_bit[2], w_btn_bit[3]};

    // Output registers load only on a difference, and the strobe marks
    // exactly the edge on which the load happens.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            r_out0 <= '0;
            r_out1 <= '0;
            r_chg0 <= 1'b0;
            r_chg1 <= 1'b0;
        end else begin
            r_chg0 <= (w_code0 != r_out0);
            r_chg1 <= (w_code1 != r_out1);
            if (w_code0 != r_out0) begin
                r_out0 <= w_code0;
            end
            if (w_code1 != r_out1) begin
                r_out1 <= w_code1;
            end
        end
    end

    assign User0    = r_out0[5:3];
    assign Func0    = r_out0[2:0];
    assign User1    = r_out1[5:3];
    assign Func1    = r_out1[2:0];
    assign Changed0 = r_chg0;
    assign Changed1 = r_chg1;

endmodule

// File: tb/tb_capturador_de_comandos.sv
// tb/tb_capturador_de_comandos.sv - directed self-checking bench for capturador_de_comandos

module tb_capturador_de_comandos;

`ifdef CAPT_STICKY_BTN_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif

    logic       Clk = 1'b0;
    logic       Reset_n;
    logic [7:0] CH;
    logic [3:0] BTN;
    logic [2:0] User0;
    logic [2:0] Func0;
    logic [2:0] User1;
    logic [2:0] Func1;
    logic       Changed0;
    logic       Changed1;

    int n_cmp = 0;
    int n_err = 0;
    int n_pulse0 = 0;

    capturador_de_comandos #(
        .DEB_CYCLES (4),
        .CNT_W      (3)
    ) dut (
        .Clk      (Clk),
        .Reset_n  (Reset_n),
        .CH       (CH),
        .BTN      (BTN),
        .User0    (User0),
        .Func0    (Func0),
        .User1    (User1),
        .Func1    (Func1),
        .Changed0 (Changed0),
        .Changed1 (Changed1)
    );

    always #5 Clk = ~Clk;

    // One rising edge, then settle 1 time unit so outputs are sampled away
    // from the edge and new inputs are set up for the next edge.
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Hold BTN0 low for 6 edges, then release; check Func0 and Changed0 over
    // the press (accept at edge 7) and the release (accept at edge 13).
    task automatic press_btn0(input logic [2:0] f_press, input logic [2:0] f_rel,
                              input logic rel_pulse, input logic [2:0] f_before);
        logic [2:0] exp_f;
        logic       exp_c;
        BTN[0] = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            tick();
            if (k == 6) BTN[0] = 1'b1;
            if (Changed0) n_pulse0++;
            exp_f = (k < 7) ? f_before : (k < 13) ? f_press : f_rel;
            exp_c = (k == 7) || ((k == 13) && rel_pulse);
            check($sformatf("btn0_func0_e%0d", k), {5'd0, Func0}, {5'd0, exp_f});
            check($sformatf("btn0_chg0_e%0d", k), {7'd0, Changed0}, {7'd0, exp_c});
        end
    endtask

    initial begin
        logic [2:0] exp_f1;

        // Reset with all raw inputs at their non-reset levels.
        Reset_n = 1'b0;
        CH      = 8'hFF;
        BTN     = 4'h0;
        repeat (3) tick();
        check("rst_user0", {5'd0, User0}, 8'd0);
        check("rst_func0", {5'd0, Func0}, 8'd0);
        check("rst_user1", {5'd0, User1}, 8'd0);
        check("rst_func1", {5'd0, Func1}, 8'd0);
        check("rst_chg", {6'd0, Changed1, Changed0}, 8'd0);

        // Clean switch change: CH0 and CH2 high from edge 1, output at edge 7.
        Reset_n = 1'b1;
        CH      = 8'b0000_0101;
        BTN     = 4'hF;
        for (int k = 1; k <= 8; k++) begin
            tick();
            check($sformatf("clean_user0_e%0d", k), {5'd0, User0},
                  (k >= 7) ? 8'd5 : 8'd0);
            check($sformatf("clean_chg0_e%0d", k), {7'd0, Changed0},
                  (k == 7) ? 8'd1 : 8'd0);
            check($sformatf("clean_chg1_e%0d", k), {7'd0, Changed1}, 8'd0);
        end

        // Glitch on BTN2 lasting 3 cycles must be discarded.
        BTN[2] = 1'b0;
        repeat (3) tick();
        BTN[2] = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            check($sformatf("glitch_func1_e%0d", k), {5'd0, Func1}, 8'd0);
            check($sformatf("glitch_chg1_e%0d", k), {7'd0, Changed1}, 8'd0);
        end

        // 6-cycle press of BTN2: Func1 = 010 at edge 7. Release accepted at
        // edge 13 in level mode; ignored in toggle mode.
        BTN[2] = 1'b0;
        for (int k = 1; k <= 14; k++) begin
            tick();
            if (k == 6) BTN[2] = 1'b1;
            exp_f1 = (k < 7) ? 3'b000 : (k < 13 || STICKY) ? 3'b010 : 3'b000;
            check($sformatf("press_func1_e%0d", k), {5'd0, Func1}, {5'd0, exp_f1});
            check($sformatf("press_chg1_e%0d", k), {7'd0, Changed1},
                  ((k == 7) || (k == 13 && !STICKY)) ? 8'd1 : 8'd0);
        end

        // Dual channel: both channels update and strobe on the same edge.
        CH = 8'b0111_0111;
        for (int k = 1; k <= 8; k++) begin
            tick();
            check($sformatf("dual_chg_e%0d", k), {6'd0, Changed1, Changed0},
                  (k == 7) ? 8'd3 : 8'd0);
        end
        check("dual_user0", {5'd0, User0}, 8'd7);
        check("dual_user1", {5'd0, User1}, 8'd7);
        check("dual_func0", {5'd0, Func0}, 8'd0);
        check("dual_func1", {5'd0, Func1}, STICKY ? 8'd2 : 8'd0);

        // Reset mid-count: CH3 rises, reset at edge 4 aborts the count.
        CH = 8'b0111_1111;
        repeat (3) tick();
        check("mid_func0_pre", {5'd0, Func0}, 8'd0);
        Reset_n = 1'b0;
        tick();
        check("mid_rst_outs", {2'd0, User0, Func0}, 8'd0);
        check("mid_rst_outs1", {2'd0, User1, Func1}, 8'd0);
        check("mid_rst_chg", {6'd0, Changed1, Changed0}, 8'd0);
        Reset_n = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            check($sformatf("mid_func0_e%0d", k), {5'd0, Func0},
                  (k >= 7) ? 8'd4 : 8'd0);
            check($sformatf("mid_chg0_e%0d", k), {7'd0, Changed0},
                  (k == 7) ? 8'd1 : 8'd0);
        end
        check("mid_user0", {5'd0, User0}, 8'd7);

        // Two separate presses of BTN0 (CH3 still high, so Func0[2] = 1).
        if (STICKY) begin
            press_btn0(3'b110, 3'b110, 1'b0, 3'b100);
            press_btn0(3'b100, 3'b100, 1'b0, 3'b110);
            check("sticky_pulses", 8'(n_pulse0), 8'd2);
        end else begin
            press_btn0(3'b110, 3'b100, 1'b1, 3'b100);
            press_btn0(3'b110, 3'b100, 1'b1, 3'b100);
            check("level_pulses", 8'(n_pulse0), 8'd4);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
